// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the instruction decode stage: opcode values,
// instruction field bit positions, the packed ID/EX payload and a small
// sign-extension helper.
// No ports (package).
// ---------------------------------------------------------------------------
package id_pkg;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int ALU_HI = 5;
    localparam int ALU_LO = 0;

    typedef enum logic [5:0] {
        OP_ALU  = 6'h00,
        OP_ADDI = 6'h01,
        OP_LW   = 6'h02,
        OP_SW   = 6'h03,
        OP_BEQ  = 6'h04,
        OP_JAL  = 6'h05,
        OP_RET  = 6'h06
    } opcode_t;

    typedef struct packed {
        logic        is_jump;
        logic        is_return;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        reg_write;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc_plus_four;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [5:0]  aluop;
    } id_ex_t;

    // A bubble is simply the all-zero payload
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit register file with two combinational read ports and one
// synchronous write port. r0 always reads zero and never stores a value.
// A write happening in the same cycle as a read of the same register is
// forwarded so the reader sees the new value immediately.
// Ports:
//   clk, rst           clock, asynchronous active-low reset (clears all regs)
//   rs1_addr/rs1_data  read port 1
//   rs2_addr/rs2_data  read port 2
//   write_enable, write_addr, write_data   writeback port
// ---------------------------------------------------------------------------
module regfile
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        write_enable,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_addr != 5'd0)) begin
            regs[write_addr] <= write_data;
        end
    end

    // Same-cycle writeback bypass; r0 is forced to zero regardless
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (write_enable && (write_addr == rs1_addr)) begin
            rs1_data = write_data;
        end
        if (write_enable && (write_addr == rs2_addr)) begin
            rs2_data = write_data;
        end
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction decode stage. Decodes the instruction returned by the
// synchronous instruction memory, reads operands, detects load-use and
// redirect hazards and registers the result into the ID/EX pipeline register.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   IF_instr                 instruction for the PC presented last cycle
//   IF_PC_out                current fetch PC (word address)
//   IF_flush                 IF_instr is wrong-path
//   EX_branch_out            branch taken in EX this cycle
//   WB_regWrite/WB_rd/WB_data  writeback port into the register file
//   PCWrite                  fetch update enable, low for a load-use stall
//   ID_EX_*                  registered decode results
// ---------------------------------------------------------------------------
module id_stage
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_instr,
    input  logic [31:0] IF_PC_out,
    input  logic        IF_flush,
    input  logic        EX_branch_out,
    input  logic        WB_regWrite,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    output logic        PCWrite,
    output logic        ID_EX_isJump,
    output logic        ID_EX_isReturn,
    output logic        ID_EX_isBranch,
    output logic        ID_EX_isLoad,
    output logic        ID_EX_isStore,
    output logic        ID_EX_regWrite,
    output logic [31:0] ID_EX_rs1_data,
    output logic [31:0] ID_EX_rs2_data,
    output logic [31:0] ID_EX_imm,
    output logic [31:0] ID_EX_PC_plus_four,
    output logic [4:0]  ID_EX_rd,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [5:0]  ID_EX_aluop
);

    logic [31:0] pc_q;
    id_ex_t      id_ex_q;
    id_ex_t      decoded;
    id_ex_t      id_ex_d;

    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        redirect;
    logic        load_use;

    assign opcode = IF_instr[OPC_HI:OPC_LO];
    assign rd     = IF_instr[RD_HI:RD_LO];
    assign rs1    = IF_instr[RS1_HI:RS1_LO];
    assign rs2    = IF_instr[RS2_HI:RS2_LO];

    regfile u_regfile (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1),
        .rs2_addr     (rs2),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .write_enable (WB_regWrite),
        .write_addr   (WB_rd),
        .write_data   (WB_data)
    );

    // Hazards: a redirect or flush already bubbles the slot, so a load-use
    // stall is only raised when the instruction would otherwise issue
    assign redirect = id_ex_q.is_jump | id_ex_q.is_return | EX_branch_out;
    assign load_use = id_ex_q.is_load & id_ex_q.reg_write & (id_ex_q.rd != 5'd0)
                    & ((id_ex_q.rd == rs1) | (id_ex_q.rd == rs2))
                    & ~redirect & ~IF_flush;
    assign PCWrite  = ~load_use;

    // Decode; every recognised opcode carries its raw fields and operands,
    // unknown opcodes fall back to a bubble
    always_comb begin
        decoded              = ID_EX_BUBBLE;
        decoded.rs1_data     = rs1_data;
        decoded.rs2_data     = rs2_data;
        decoded.imm          = sign_extend16(IF_instr[IMM_HI:IMM_LO]);
        decoded.pc_plus_four = pc_q + 32'd1;
        decoded.rd           = rd;
        decoded.rs1          = rs1;
        decoded.rs2          = rs2;
        case (opcode)
            OP_ALU: begin
                decoded.reg_write = 1'b1;
                decoded.aluop     = IF_instr[ALU_HI:ALU_LO];
            end
            OP_ADDI: decoded.reg_write = 1'b1;
            OP_LW: begin
                decoded.is_load   = 1'b1;
                decoded.reg_write = 1'b1;
            end
            OP_SW:  decoded.is_store  = 1'b1;
            OP_BEQ: decoded.is_branch = 1'b1;
            OP_JAL: begin
                decoded.is_jump   = 1'b1;
                decoded.reg_write = 1'b1;
            end
            OP_RET: decoded.is_return = 1'b1;
            default: decoded = ID_EX_BUBBLE;
        endcase
    end

    always_comb begin
        id_ex_d = decoded;
        if (redirect || IF_flush || load_use) begin
            id_ex_d = ID_EX_BUBBLE;
        end
    end

    // pc_q tracks the PC whose instruction is currently on IF_instr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            if (PCWrite) begin
                pc_q <= IF_PC_out;
            end
            id_ex_q <= id_ex_d;
        end
    end

    assign ID_EX_isJump       = id_ex_q.is_jump;
    assign ID_EX_isReturn     = id_ex_q.is_return;
    assign ID_EX_isBranch     = id_ex_q.is_branch;
    assign ID_EX_isLoad       = id_ex_q.is_load;
    assign ID_EX_isStore      = id_ex_q.is_store;
    assign ID_EX_regWrite     = id_ex_q.reg_write;
    assign ID_EX_rs1_data     = id_ex_q.rs1_data;
    assign ID_EX_rs2_data     = id_ex_q.rs2_data;
    assign ID_EX_imm          = id_ex_q.imm;
    assign ID_EX_PC_plus_four = id_ex_q.pc_plus_four;
    assign ID_EX_rd           = id_ex_q.rd;
    assign ID_EX_rs1          = id_ex_q.rs1;
    assign ID_EX_rs2          = id_ex_q.rs2;
    assign ID_EX_aluop        = id_ex_q.aluop;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset; asynchronous, active-low.
REQ-003 IF_instr  input  32  instruction from synchronous imem; valid one cycle after its PC is presented.
REQ-004 IF_PC_out  input  32  current fetch PC (word address).
REQ-005 IF_flush  input  1  high when IF_instr is wrong-path after a redirect.
REQ-006 EX_branch_out  input  1  branch taken in EX this cycle.
REQ-007 WB_regWrite, WB_rd[4:0], WB_data[31:0]  input  writeback port.
REQ-008 PCWrite  output  1  fetch PC/flush update enable; low during load-use stall.
REQ-009 ID_EX_isJump, ID_EX_isReturn, ID_EX_isBranch, ID_EX_isLoad, ID_EX_isStore, ID_EX_regWrite  output  1 each  registered controls.
REQ-010 ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_PC_plus_four  output  32 each  registered operands; imm sign-extended.
REQ-011 ID_EX_rd, ID_EX_rs1, ID_EX_rs2  output  5 each; ID_EX_aluop  output  6.

Function
REQ-012 Encoding: opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm [15:0], aluop = [5:0] for ALU ops else 0.
REQ-013 Opcodes: ALU 0x00, ADDI 0x01, LW 0x02, SW 0x03, BEQ 0x04, JAL 0x05 (writes PC+1 link to rd), RET 0x06; any other opcode decodes as bubble.
REQ-014 PC alignment register pc_q captures IF_PC_out when PCWrite=1; pc_q is the PC of IF_instr; ID_EX_PC_plus_four = pc_q + 1, modulo 2^32.
REQ-015 Register file 32x32; r0 reads 0 and ignores writes; write on posedge when WB_regWrite=1.
REQ-016 Read bypass: WB_regWrite=1 and WB_rd==rsX, rsX!=0, same cycle -> read returns WB_data.
REQ-017 redirect = ID_EX_isJump | ID_EX_isReturn | EX_branch_out.
REQ-018 load_use = ID_EX_isLoad & ID_EX_regWrite & ID_EX_rd!=0 & (ID_EX_rd==rs1 | ID_EX_rd==rs2) of current IF_instr, and not redirect, and not IF_flush.
REQ-019 Bubble = all ID_EX control bits 0, all data/index fields 0.
REQ-020 Each cycle ID/EX loads: bubble if redirect or IF_flush or load_use; else decoded IF_instr.
REQ-021 PCWrite = !load_use; stall lasts exactly one cycle (next cycle ID_EX_isLoad=0).
REQ-022 Priority: redirect > IF_flush > load_use > normal issue.
REQ-023 Simultaneous WB write and stall: write completes; re-decoded instruction next cycle sees new value.
REQ-024 Latency: decode-to-ID/EX one clock; no combinational path from IF_instr to any output except PCWrite.

Reset
REQ-025 rst low asynchronously clears pc_q, all ID/EX outputs (bubble), all 32 registers; PCWrite reads 1 during and after reset.
REQ-026 Reset mid-stall or mid-redirect discards in-flight state; first post-reset ID/EX is decoded from the instruction at PC 0.

Structure
REQ-027 Package id_pkg holds opcode constants, field bit positions, and a packed id_ex_t struct for the ID/EX payload.
REQ-028 Sub-module regfile (2 read, 1 write, bypass, r0 zero) instantiated once; hazard and decode logic in id_stage.

Verification
REQ-029 Reset then ADDI r1,r0,5 then ALU add r2,r1,r1 with WB writing r1=5 same cycle as second decode -> ID_EX_rs1_data=ID_EX_rs2_data=5.
REQ-030 ID_EX = LW r3; IF_instr = ALU using rs1=r3 -> PCWrite=0 one cycle, bubble in ID/EX, ALU issued next cycle with PCWrite=1.
REQ-031 LW r0 followed by use of r0 -> no stall, PCWrite stays 1.
REQ-032 ID_EX_isJump=1 with load_use condition present -> bubble, PCWrite=1; next cycle IF_flush=1 -> second bubble.
REQ-033 WB_regWrite=1, WB_rd=0, WB_data=0xDEADBEEF -> subsequent read of r0 returns 0.
REQ-034 Assert rst low during stall -> all ID_EX outputs 0, PCWrite=1, r5 reads 0 after release.
